// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
// multicycle_ctrl: IF/ID/EX/MEM/WB control sequencer for the R/I/J MIPS-subset CPU.
// It drives a shared datapath made of one ALU, one register file and a PC with a PC+4 adder.
// Ports:
//   clk, rst_n                rising-edge clock, asynchronous active-low reset
//   op, func                  IR[31:26] and IR[5:0], taken from the registered IR
//   zf                        ALU zero flag, used by beq/bne in EX
//   imem_ready, dmem_ready    instruction fetch / data access handshakes
//   ir_write, pc_write        IR and PC load strobes
//   pc_s, w_r_s, imm_s, rt_imm_s, wr_data_s, alu_op   datapath selects
//   write_reg, mem_read, mem_write                    register-file and data-memory strobes
//   instr_done, illegal, err  end-of-instruction pulse, bad-opcode pulse, sticky watchdog error
// All outputs are combinational from state and inputs. Strobes are gated by rst_n so they are
// low for the whole reset, even though IF with imem_ready=1 would otherwise load IR and PC.
module multicycle_ctrl #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zf,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_s,
    output logic [1:0] w_r_s,
    output logic       imm_s,
    output logic       rt_imm_s,
    output logic [1:0] wr_data_s,
    output logic [3:0] alu_op,
    output logic       write_reg,
    output logic       mem_read,
    output logic       mem_write,
    output logic       instr_done,
    output logic       illegal,
    output logic       err
);

    localparam logic [2:0] StIf  = 3'd0;
    localparam logic [2:0] StId  = 3'd1;
    localparam logic [2:0] StEx  = 3'd2;
    localparam logic [2:0] StMem = 3'd3;
    localparam logic [2:0] StWb  = 3'd4;
    localparam logic [2:0] StErr = 3'd7;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSltiu = 6'b001011;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpXori  = 6'b001110;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FnSllv = 6'b000100;
    localparam logic [5:0] FnJr   = 6'b001000;
    localparam logic [5:0] FnAdd  = 6'b100000;
    localparam logic [5:0] FnSub  = 6'b100010;
    localparam logic [5:0] FnAnd  = 6'b100100;
    localparam logic [5:0] FnOr   = 6'b100101;
    localparam logic [5:0] FnXor  = 6'b100110;
    localparam logic [5:0] FnNor  = 6'b100111;
    localparam logic [5:0] FnSltu = 6'b101011;

    localparam logic [3:0] AluAnd  = 4'b0000;
    localparam logic [3:0] AluOr   = 4'b0001;
    localparam logic [3:0] AluXor  = 4'b0010;
    localparam logic [3:0] AluNor  = 4'b0011;
    localparam logic [3:0] AluAdd  = 4'b0100;
    localparam logic [3:0] AluSub  = 4'b0101;
    localparam logic [3:0] AluSltu = 4'b0110;
    localparam logic [3:0] AluSllv = 4'b0111;

    localparam logic [CNT_W-1:0] WaitLim = CNT_W'(WAIT_MAX);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Instruction decode
    logic       is_r, is_jr, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, legal;
    logic       imm_sext, use_imm;
    logic [3:0] alu_sel;

    always_comb begin
        is_r     = 1'b0;
        is_jr    = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jal   = 1'b0;
        legal    = 1'b1;
        imm_sext = 1'b0;
        use_imm  = 1'b0;
        alu_sel  = AluAnd;
        case (op)
            OpRtype: begin
                is_r = 1'b1;
                case (func)
                    FnAdd:   alu_sel = AluAdd;
                    FnSub:   alu_sel = AluSub;
                    FnAnd:   alu_sel = AluAnd;
                    FnOr:    alu_sel = AluOr;
                    FnXor:   alu_sel = AluXor;
                    FnNor:   alu_sel = AluNor;
                    FnSltu:  alu_sel = AluSltu;
                    FnSllv:  alu_sel = AluSllv;
                    FnJr:    is_jr   = 1'b1;
                    default: legal   = 1'b0;
                endcase
            end
            OpAddi:  begin alu_sel = AluAdd;  imm_sext = 1'b1; use_imm = 1'b1; end
            OpAndi:  begin alu_sel = AluAnd;  use_imm = 1'b1; end
            OpXori:  begin alu_sel = AluXor;  use_imm = 1'b1; end
            OpSltiu: begin alu_sel = AluSltu; use_imm = 1'b1; end
            OpLw:    begin is_lw = 1'b1; alu_sel = AluAdd; imm_sext = 1'b1; use_imm = 1'b1; end
            OpSw:    begin is_sw = 1'b1; alu_sel = AluAdd; imm_sext = 1'b1; use_imm = 1'b1; end
            OpBeq:   begin is_beq = 1'b1; alu_sel = AluSub; end
            OpBne:   begin is_bne = 1'b1; alu_sel = AluSub; end
            OpJ:     is_j   = 1'b1;
            OpJal:   is_jal = 1'b1;
            default: legal  = 1'b0;
        endcase
    end

    // A ready in the limit cycle is checked first, so it completes rather than trapping.
    logic wd_hit;
    assign wd_hit = (WAIT_MAX != 0) && (cnt_q == WaitLim);

    logic ir_write_c, pc_write_c, write_reg_c, mem_read_c, mem_write_c, done_c, illegal_c;

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        write_reg_c = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        done_c      = 1'b0;
        illegal_c   = 1'b0;
        pc_s        = 2'b00;
        w_r_s       = 2'b00;
        imm_s       = 1'b0;
        rt_imm_s    = 1'b0;
        wr_data_s   = 2'b00;
        alu_op      = AluAnd;
        case (state_q)
            StIf: begin
                if (imem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = StId;
                end else if (wd_hit) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StId: begin
                if (!legal) begin
                    illegal_c = 1'b1;
                    done_c    = 1'b1;
                    state_d   = StIf;
                end else if (is_j || is_jal) begin
                    pc_write_c = 1'b1;
                    pc_s       = 2'b11;
                    done_c     = 1'b1;
                    state_d    = StIf;
                    if (is_jal) begin
                        write_reg_c = 1'b1;
                        w_r_s       = 2'b10;
                        wr_data_s   = 2'b10;
                    end
                end else begin
                    state_d = StEx;
                end
            end
            StEx: begin
                alu_op   = alu_sel;
                imm_s    = imm_sext;
                rt_imm_s = use_imm;
                if (is_jr) begin
                    pc_write_c = 1'b1;
                    pc_s       = 2'b01;
                    done_c     = 1'b1;
                    state_d    = StIf;
                end else if (is_beq || is_bne) begin
                    pc_write_c = is_beq ? zf : !zf;
                    pc_s       = 2'b10;
                    done_c     = 1'b1;
                    state_d    = StIf;
                end else if (is_lw || is_sw) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                alu_op      = AluAdd;
                imm_s       = 1'b1;
                rt_imm_s    = 1'b1;
                mem_read_c  = is_lw;
                mem_write_c = is_sw;
                if (dmem_ready) begin
                    done_c  = is_sw;
                    state_d = is_lw ? StWb : StIf;
                end else if (wd_hit) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWb: begin
                // Hold the EX selects so the ALU result being written stays stable.
                alu_op      = alu_sel;
                imm_s       = imm_sext;
                rt_imm_s    = use_imm;
                write_reg_c = 1'b1;
                done_c      = 1'b1;
                w_r_s       = is_r ? 2'b00 : 2'b01;
                wr_data_s   = is_lw ? 2'b01 : 2'b00;
                state_d     = StIf;
            end
            StErr: state_d = StErr;
            default: state_d = StIf;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIf;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ir_write   = rst_n & ir_write_c;
    assign pc_write   = rst_n & pc_write_c;
    assign write_reg  = rst_n & write_reg_c;
    assign mem_read   = rst_n & mem_read_c;
    assign mem_write  = rst_n & mem_write_c;
    assign instr_done = rst_n & done_c;
    assign illegal    = rst_n & illegal_c;
    assign err        = (state_q == StErr);

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for multicycle_ctrl: each instruction pushes its expected per-cycle output
// records (with the ready inputs to apply) and the records are popped and compared cycle by cycle.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_s;
        logic [1:0] w_r_s;
        logic       imm_s;
        logic       rt_imm_s;
        logic [1:0] wr_data_s;
        logic [3:0] alu_op;
        logic       write_reg;
        logic       mem_read;
        logic       mem_write;
        logic       instr_done;
        logic       illegal;
        logic       err;
    } out_t;

    typedef struct packed {
        logic imem;
        logic dmem;
        out_t o;
    } rec_t;

    typedef enum int {KR, KJr, KIalu, KLw, KSw, KBeq, KBne, KJ, KJal, KIll} kind_e;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, func;
    logic       zf, imem_ready, dmem_ready;
    logic       ir_write, pc_write, imm_s, rt_imm_s, write_reg, mem_read, mem_write;
    logic       instr_done, illegal, err;
    logic [1:0] pc_s, w_r_s, wr_data_s;
    logic [3:0] alu_op;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc;
    int   done_cyc;

    always #5 clk = ~clk;

    multicycle_ctrl #(.WAIT_MAX(15), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .func       (func),
        .zf         (zf),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_s       (pc_s),
        .w_r_s      (w_r_s),
        .imm_s      (imm_s),
        .rt_imm_s   (rt_imm_s),
        .wr_data_s  (wr_data_s),
        .alu_op     (alu_op),
        .write_reg  (write_reg),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .instr_done (instr_done),
        .illegal    (illegal),
        .err        (err)
    );

    function automatic out_t observed();
        return {ir_write, pc_write, pc_s, w_r_s, imm_s, rt_imm_s, wr_data_s, alu_op,
                write_reg, mem_read, mem_write, instr_done, illegal, err};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic im, input logic dm, input out_t o);
        rec_t r;
        r.imem = im;
        r.dmem = dm;
        r.o    = o;
        exp_q.push_back(r);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, written from the instruction table.
    task automatic push_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                              input int w_if, input int w_mem);
        kind_e k;
        logic [3:0] alu;
        logic sx, ui;
        out_t e, ex;
        op = o; func = f; zf = z;
        k = KIll; alu = 4'b0000; sx = 1'b0; ui = 1'b0;
        case (o)
            6'b000000: begin
                k = KR;
                case (f)
                    6'b100000: alu = 4'b0100;
                    6'b100010: alu = 4'b0101;
                    6'b100100: alu = 4'b0000;
                    6'b100101: alu = 4'b0001;
                    6'b100110: alu = 4'b0010;
                    6'b100111: alu = 4'b0011;
                    6'b101011: alu = 4'b0110;
                    6'b000100: alu = 4'b0111;
                    6'b001000: k = KJr;
                    default:   k = KIll;
                endcase
            end
            6'b001000: begin k = KIalu; alu = 4'b0100; sx = 1'b1; ui = 1'b1; end
            6'b001100: begin k = KIalu; alu = 4'b0000; ui = 1'b1; end
            6'b001110: begin k = KIalu; alu = 4'b0010; ui = 1'b1; end
            6'b001011: begin k = KIalu; alu = 4'b0110; ui = 1'b1; end
            6'b100011: begin k = KLw;   alu = 4'b0100; sx = 1'b1; ui = 1'b1; end
            6'b101011: begin k = KSw;   alu = 4'b0100; sx = 1'b1; ui = 1'b1; end
            6'b000100: begin k = KBeq;  alu = 4'b0101; end
            6'b000101: begin k = KBne;  alu = 4'b0101; end
            6'b000010: k = KJ;
            6'b000011: k = KJal;
            default:   k = KIll;
        endcase
        for (int i = 0; i < w_if; i++) push(1'b0, 1'b1, '0);
        e = '0; e.ir_write = 1'b1; e.pc_write = 1'b1;
        push(1'b1, 1'b1, e);
        // ID
        e = '0;
        if (k == KJ || k == KJal) begin
            e.pc_write = 1'b1; e.pc_s = 2'b11; e.instr_done = 1'b1;
            if (k == KJal) begin e.write_reg = 1'b1; e.w_r_s = 2'b10; e.wr_data_s = 2'b10; end
            push(1'b1, 1'b1, e);
            return;
        end
        if (k == KIll) begin
            e.illegal = 1'b1; e.instr_done = 1'b1;
            push(1'b1, 1'b1, e);
            return;
        end
        push(1'b1, 1'b1, e);
        // EX
        ex = '0; ex.alu_op = alu; ex.imm_s = sx; ex.rt_imm_s = ui;
        e = ex;
        if (k == KJr) begin
            e.pc_write = 1'b1; e.pc_s = 2'b01; e.instr_done = 1'b1;
            push(1'b1, 1'b1, e);
            return;
        end
        if (k == KBeq || k == KBne) begin
            e.pc_write = (k == KBeq) ? z : !z; e.pc_s = 2'b10; e.instr_done = 1'b1;
            push(1'b1, 1'b1, e);
            return;
        end
        push(1'b1, 1'b1, e);
        // MEM
        if (k == KLw || k == KSw) begin
            e = '0; e.alu_op = 4'b0100; e.imm_s = 1'b1; e.rt_imm_s = 1'b1;
            e.mem_read = (k == KLw); e.mem_write = (k == KSw);
            for (int i = 0; i < w_mem; i++) push(1'b1, 1'b0, e);
            e.instr_done = (k == KSw);
            push(1'b1, 1'b1, e);
            if (k == KSw) return;
        end
        // WB
        e = ex; e.write_reg = 1'b1; e.instr_done = 1'b1;
        e.w_r_s = (k == KR) ? 2'b00 : 2'b01;
        e.wr_data_s = (k == KLw) ? 2'b01 : 2'b00;
        push(1'b1, 1'b1, e);
    endtask

    // Pop up to n records (all if n < 0); each applies its inputs at a negedge and compares 1 ns later.
    task automatic drain(input string name, input int n);
        rec_t r;
        int k = 0;
        while (exp_q.size() > 0 && (n < 0 || k < n)) begin
            r = exp_q.pop_front();
            imem_ready = r.imem;
            dmem_ready = r.dmem;
            #1;
            check($sformatf("%s c%0d", name, cyc), observed(), r.o);
            if (instr_done && done_cyc < 0) done_cyc = cyc;
            cyc++;
            k++;
            @(negedge clk);
        end
    endtask

    task automatic run(input string name, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input int w_if, input int w_mem, input int n_cyc);
        cyc = 0;
        done_cyc = -1;
        push_instr(o, f, z, w_if, w_mem);
        drain(name, -1);
        check({name, " cycles"}, done_cyc + 1, n_cyc);
    endtask

    initial begin
        out_t e;
        rst_n = 1'b0; op = 6'b000000; func = 6'b100000; zf = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset outputs", observed(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        run("add",      6'b000000, 6'b100000, 1'b0, 0, 0, 4);
        run("lw wait3", 6'b100011, 6'b000000, 1'b0, 0, 3, 8);
        run("beq z1",   6'b000100, 6'b000000, 1'b1, 0, 0, 3);
        run("beq z0",   6'b000100, 6'b000000, 1'b0, 0, 0, 3);
        run("bne z1",   6'b000101, 6'b000000, 1'b1, 0, 0, 3);
        run("bne z0",   6'b000101, 6'b000000, 1'b0, 0, 0, 3);
        run("jal",      6'b000011, 6'b000000, 1'b0, 0, 0, 2);
        run("j",        6'b000010, 6'b000000, 1'b0, 0, 0, 2);
        run("ill op",   6'b111111, 6'b000000, 1'b0, 0, 0, 2);
        run("ill func", 6'b000000, 6'b111111, 1'b0, 0, 0, 2);
        run("sub",      6'b000000, 6'b100010, 1'b0, 0, 0, 4);
        run("and",      6'b000000, 6'b100100, 1'b0, 0, 0, 4);
        run("or",       6'b000000, 6'b100101, 1'b0, 0, 0, 4);
        run("xor",      6'b000000, 6'b100110, 1'b0, 0, 0, 4);
        run("nor",      6'b000000, 6'b100111, 1'b0, 0, 0, 4);
        run("sltu",     6'b000000, 6'b101011, 1'b0, 0, 0, 4);
        run("sllv",     6'b000000, 6'b000100, 1'b0, 0, 0, 4);
        run("jr",       6'b000000, 6'b001000, 1'b0, 0, 0, 3);
        run("addi",     6'b001000, 6'b000000, 1'b0, 0, 0, 4);
        run("andi",     6'b001100, 6'b000000, 1'b0, 0, 0, 4);
        run("xori",     6'b001110, 6'b000000, 1'b0, 0, 0, 4);
        run("sltiu",    6'b001011, 6'b000000, 1'b0, 0, 0, 4);
        run("sw",       6'b101011, 6'b000000, 1'b0, 0, 0, 4);
        run("sw wait2", 6'b101011, 6'b000000, 1'b0, 0, 2, 6);
        run("add if15", 6'b000000, 6'b100000, 1'b0, 15, 0, 19);
        run("lw mem15", 6'b100011, 6'b000000, 1'b0, 0, 15, 20);

        // Watchdog: 16 IF wait cycles, then ERR is sticky even with imem_ready high.
        cyc = 0;
        for (int i = 0; i < 16; i++) push(1'b0, 1'b1, '0);
        e = '0; e.err = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b1, 1'b1, e);
        drain("watchdog", -1);
        rst_n = 1'b0;
        #1;
        check("err cleared by reset", err, 1'b0);
        check("reset strobes", observed(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while sw waits in MEM.
        cyc = 0;
        push_instr(6'b101011, 6'b000000, 1'b0, 0, 4);
        drain("sw pre", 3);
        exp_q.delete();
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check("sw mem_write in MEM", mem_write, 1'b1);
        #2;
        rst_n = 1'b0;
        #0.5;
        check("mem_write drops on reset", mem_write, 1'b0);
        check("err low in reset", err, 1'b0);
        #0.5;
        rst_n = 1'b1;
        @(negedge clk);
        imem_ready = 1'b1;
        #1;
        e = '0; e.ir_write = 1'b1; e.pc_write = 1'b1;
        check("back in IF", observed(), e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
